// File: rtl/brom_pkg.sv
// brom_pkg: shared constants and FSM encoding for the boot ROM loader
package brom_pkg;
  localparam int BROM_SIZE = 256;
  localparam int BROM_ADDR_W = $clog2(BROM_SIZE);
  localparam logic [15:0] BROM_DISABLE_ADDR = 16'hFF50;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERR, S_OFF} state_t;
endpackage

// File: rtl/brom_ram.sv
// brom_ram: boot image store, one sync write port and one sync read port with a holding output register
module brom_ram #(
  parameter int SIZE = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [7:0]        wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [7:0]        q
);
  logic [7:0] mem [SIZE];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (re) q <= mem[ra];
endmodule

// File: rtl/brom_loader.sv
// brom_loader: streams in and checksums the boot image, gates CPU reset and serves the boot overlay until disabled
module brom_loader
  import brom_pkg::*;
#(
  parameter int          SIZE = BROM_SIZE,
  parameter int          ADDR_W = BROM_ADDR_W,
  parameter logic [15:0] DISABLE_ADDR = BROM_DISABLE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_err,
  output logic        cpu_hold,
  input  logic [15:0] a,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        brom_sel
);
  state_t state, state_nx;
  logic [ADDR_W:0] cnt;
  logic [7:0] sum;
  logic brom_en, xfer, restart, data_we, unused;
  assign unused = ^din[7:1];
  assign xfer = ld_ready && ld_valid;
  assign restart = ld_start && state != S_LOAD && state != S_CHECK;
  // cnt's top bit set means the image is in and the next byte is the checksum
  assign data_we = xfer && !cnt[ADDR_W];
  assign brom_sel = brom_en && a[15:ADDR_W] == '0;
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (restart) state_nx = S_LOAD;
    else
      case (state)
        S_LOAD:  state_nx = xfer && cnt[ADDR_W] ? S_CHECK : S_LOAD;
        S_CHECK: state_nx = sum == 8'h00 ? S_RUN : S_ERR;
        S_RUN:   state_nx = wr && a == DISABLE_ADDR && din[0] ? S_OFF : S_RUN;
        S_ERR:   state_nx = S_ERR;
        S_OFF:   state_nx = S_OFF;
        default: state_nx = S_IDLE;
      endcase
  end
  always_comb begin
    ld_ready = state == S_LOAD;
    ld_done  = state == S_RUN || state == S_OFF;
    ld_err   = state == S_ERR;
    cpu_hold = !ld_done;
    brom_en  = state == S_RUN;
  end
  always_ff @(posedge clk)
    if (rst || restart) begin
      cnt <= '0;
      sum <= '0;
    end else if (xfer) begin
      sum <= sum + ld_data;
      cnt <= data_we ? cnt + 1'b1 : cnt;
    end
  brom_ram #(.SIZE(SIZE), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(data_we),
    .wa(cnt[ADDR_W-1:0]),
    .wd(ld_data),
    .re(rd && brom_sel),
    .ra(a[ADDR_W-1:0]),
    .q(dout)
  );
endmodule

// File: tb/tb_brom_loader.sv
// tb_brom_loader: scoreboard bench for the boot ROM loader
module tb_brom_loader;
  logic clk = 0, rst = 1, ld_start = 0, ld_valid = 0, rd = 0, wr = 0;
  logic [7:0] ld_data = 0, din = 0;
  logic [15:0] a = 0;
  logic ld_ready, ld_done, ld_err, cpu_hold, brom_sel;
  logic [7:0] dout;
  int passed = 0, total = 0, cyc = 0, first_cyc = 0;
  logic [7:0] img [256];
  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] cks;

  brom_loader dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .cpu_hold(cpu_hold),
    .a(a), .rd(rd), .wr(wr), .din(din), .dout(dout), .brom_sel(brom_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b, input bit gaps, input bit first);
    int n = 0;
    if (gaps)
      while ($urandom_range(1, 0) == 1) begin
        ld_valid = 0;
        @(negedge clk);
      end
    ld_data = b;
    ld_valid = 1;
    while (!ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) check("ready_timeout", 0, 1);
    if (first) first_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] c, input bit gaps, input int nb, input bit do_start);
    if (do_start) begin
      ld_start = 1;
      ld_valid = !gaps;
      ld_data = img[0];
      @(negedge clk);
      ld_start = 0;
    end
    for (int i = 0; i < nb; i++) begin
      send(img[i], gaps, i == 0);
      model[i] = img[i];
    end
    if (nb == 256) send(c, gaps, 0);
    ld_valid = 0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!ld_done && !ld_err && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rd_chk(input logic [15:0] addr, input string tag);
    a = addr;
    rd = 1;
    exp_q.push_back(model[addr[7:0]]);
    @(negedge clk);
    rd = 0;
    check(tag, dout, exp_q.pop_front());
  endtask

  task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] d);
    a = addr;
    din = d;
    wr = 1;
    @(negedge clk);
    wr = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", ld_ready, 0);
    check("rst_done", ld_done, 0);
    check("rst_err", ld_err, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_dout", dout, 0);
    check("rst_sel", brom_sel, 0);
    rst = 0;
    @(negedge clk);
    // gapless good image, byte offered during the start cycle must not be taken
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    load(8'h80, 0, 256, 1);
    wait_end();
    check("t1_latency", cyc - first_cyc, 258);
    check("t1_done", ld_done, 1);
    check("t1_err", ld_err, 0);
    check("t1_hold", cpu_hold, 0);
    check("t1_ready", ld_ready, 0);
    rd_chk(16'h0042, "t1_rd42");
    check("t1_dout42", dout, 8'h42);
    // bad checksum
    load(8'h81, 0, 256, 1);
    wait_end();
    check("t2_err", ld_err, 1);
    check("t2_done", ld_done, 0);
    check("t2_hold", cpu_hold, 1);
    a = 16'h0000;
    #1 check("t2_sel", brom_sel, 0);
    rd = 1;
    @(negedge clk);
    rd = 0;
    check("t2_dout_hold", dout, 8'h42);
    // random image, random valid gaps, full scoreboard sweep
    cks = 0;
    for (int i = 0; i < 256; i++) begin
      img[i] = 8'($urandom);
      cks -= img[i];
    end
    load(cks, 1, 256, 1);
    wait_end();
    check("t3_done", ld_done, 1);
    check("t3_err", ld_err, 0);
    for (int i = 0; i < 256; i++) rd_chk(16'(i), "t3_sweep");
    // CPU writes to the array and non-disabling register writes
    cpu_wr(16'h0010, ~model[16]);
    cpu_wr(16'hFF50, 8'h00);
    cpu_wr(16'hFF50, 8'hFE);
    a = 16'h0000;
    #1 check("t4_sel_kept", brom_sel, 1);
    rd_chk(16'h0010, "t4_ro");
    repeat (3) @(negedge clk);
    check("t4_dout_idle", dout, model[16]);
    cpu_wr(16'hFF50, 8'h01);
    a = 16'h0000;
    #1 check("t4_sel_off", brom_sel, 0);
    check("t4_off_done", ld_done, 1);
    check("t4_off_hold", cpu_hold, 0);
    rd = 1;
    @(negedge clk);
    rd = 0;
    check("t4_off_dout", dout, model[16]);
    repeat (1000) @(negedge clk);
    check("t4_sel_1000", brom_sel, 0);
    // restart from OFF, abort with reset after 100 bytes
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    load(8'h80, 0, 100, 1);
    rst = 1;
    @(negedge clk);
    check("t5_ready", ld_ready, 0);
    check("t5_hold", cpu_hold, 1);
    check("t5_done", ld_done, 0);
    rst = 0;
    @(negedge clk);
    check("t5_idle_ready", ld_ready, 0);
    load(8'h80, 0, 256, 1);
    wait_end();
    check("t5_reload_done", ld_done, 1);
    rd_chk(16'h0042, "t5_rd42");
    // ld_start pulse while running, reload inverted image
    ld_start = 1;
    @(negedge clk);
    ld_start = 0;
    check("t6_done", ld_done, 0);
    check("t6_hold", cpu_hold, 1);
    check("t6_ready", ld_ready, 1);
    for (int i = 0; i < 256; i++) img[i] = 8'(255 - i);
    load(8'h80, 0, 256, 0);
    wait_end();
    check("t6_reload_done", ld_done, 1);
    rd_chk(16'h0042, "t6_rd42");
    check("t6_dout_bd", dout, 8'hBD);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
